async_fifo_wr_ptr: RTL and testbench

Write-side pointer and flag generator for the clock-domain-crossing FIFO. It counts accepted writes and produces the memory write address. It also produces a registered Gray-coded write pointer, which is the only multi-bit signal allowed into the downstream two-flop synchronizer. It consumes the read pointer after that pointer has been synchronized into this domain, and derives full, almost-full, fill count and overflow from it.

---
 rtl/async_fifo_wr_ptr.sv | 84 ++++++++
 tb/tb_async_fifo_wr_ptr.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_wr_ptr.sv
// Write-side pointer and flag generator for the dual-clock FIFO: binary/Gray write
// pointer, full, almost-full, fill count and overflow, from a pre-synchronized read pointer.
module async_fifo_wr_ptr #(
  parameter int S        = 12,
  parameter int AF_LEVEL = 2040
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [S-1:0] rd_ptr_gray_sync,
  output logic         wr_mem_en,
  output logic [S-2:0] wr_addr,
  output logic [S-1:0] wr_ptr_gray,
  output logic         full,
  output logic         almost_full,
  output logic [S-1:0] wr_count,
  output logic         overflow
);

  localparam logic [S:0] AF_THRESH = (S+1)'(AF_LEVEL);

  logic [S-1:0] wr_bin_q, wr_bin_d;
  logic [S-1:0] wr_gray_q, wr_gray_d;
  logic [S-1:0] count_q, count_d;
  logic         full_q, full_d;
  logic         af_q, af_d;
  logic         ovf_q, ovf_d;
  logic         accept;
  logic [S-1:0] rd_bin;
  logic [S-1:0] full_match;

  assign accept = wr_en & ~full_q;

  // Gray-to-binary of the synchronized read pointer, MSB downwards.
  always_comb begin
    logic acc;
    rd_bin        = '0;
    acc           = rd_ptr_gray_sync[S-1];
    rd_bin[S-1]   = acc;
    for (int i = S - 2; i >= 0; i--) begin
      acc       = acc ^ rd_ptr_gray_sync[i];
      rd_bin[i] = acc;
    end
  end

  // Full means the writer is exactly one lap ahead: top two Gray bits inverted.
  assign full_match = {~rd_ptr_gray_sync[S-1:S-2], rd_ptr_gray_sync[S-3:0]};

  always_comb begin
    wr_bin_d  = wr_bin_q + {{(S-1){1'b0}}, accept};
    wr_gray_d = wr_bin_d ^ (wr_bin_d >> 1);
    count_d   = wr_bin_d - rd_bin;
    full_d    = (wr_gray_d == full_match);
    af_d      = ({1'b0, count_d} >= AF_THRESH);
    ovf_d     = wr_en & full_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bin_q  <= '0;
      wr_gray_q <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      af_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_bin_q  <= wr_bin_d;
      wr_gray_q <= wr_gray_d;
      count_q   <= count_d;
      full_q    <= full_d;
      af_q      <= af_d;
      ovf_q     <= ovf_d;
    end
  end

  assign wr_mem_en   = accept;
  assign wr_addr     = wr_bin_q[S-2:0];
  assign wr_ptr_gray = wr_gray_q;
  assign full        = full_q;
  assign almost_full = af_q;
  assign wr_count    = count_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_async_fifo_wr_ptr.sv
// Bench for async_fifo_wr_ptr at S=4 (depth 8), AF_LEVEL=6: directed vector table,
// wrap and reset sequences, and random traffic against an occupancy-counting model.
module tb_async_fifo_wr_ptr;

  localparam int S  = 4;
  localparam int AF = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic [S-1:0] rd_ptr_gray_sync;
  logic         wr_mem_en;
  logic [S-2:0] wr_addr;
  logic [S-1:0] wr_ptr_gray;
  logic         full;
  logic         almost_full;
  logic [S-1:0] wr_count;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  // Model state: total accepted writes and total reads since reset, as plain integers.
  int mWrites = 0;
  int mReads  = 0;
  bit mFull   = 1'b0;

  typedef struct {
    logic       rst;
    logic       wrEn;
    logic [3:0] rdG;
    logic       memEn;
    logic [3:0] gray;
    logic [2:0] addr;
    logic [3:0] count;
    logic       full;
    logic       af;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];

  async_fifo_wr_ptr #(.S(S), .AF_LEVEL(AF)) dut (
    .clk              (clk),
    .rst              (rst),
    .wr_en            (wr_en),
    .rd_ptr_gray_sync (rd_ptr_gray_sync),
    .wr_mem_en        (wr_mem_en),
    .wr_addr          (wr_addr),
    .wr_ptr_gray      (wr_ptr_gray),
    .full             (full),
    .almost_full      (almost_full),
    .wr_count         (wr_count),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] toGray(input int n);
    logic [3:0] b;
    b = 4'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs shortly after an edge and let the combinational strobe settle.
  task automatic applyStimulus(input logic r, input logic w, input logic [3:0] g);
    rst              = r;
    wr_en            = w;
    rd_ptr_gray_sync = g;
    #1;
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  // One cycle checked against the model; newReads is the read count visible this cycle.
  task automatic cycleModel(input logic r, input logic w, input int newReads, input string tag);
    int  occ;
    bit  acc;
    bit  expOvf;
    applyStimulus(r, w, toGray(newReads));
    checkOutput({tag, ".memEn"}, 32'(wr_mem_en), 32'(w && !mFull));
    stepEdge();
    if (r) begin
      mWrites = 0;
      mReads  = 0;
      mFull   = 1'b0;
      expOvf  = 1'b0;
    end else begin
      acc     = w && !mFull;
      expOvf  = w && mFull;
      mWrites = mWrites + int'(acc);
      mReads  = newReads;
      mFull   = ((mWrites - mReads) == 8);
    end
    occ = mWrites - mReads;
    checkOutput({tag, ".gray"},  32'(wr_ptr_gray), 32'(toGray(mWrites)));
    checkOutput({tag, ".addr"},  32'(wr_addr),     32'(mWrites % 8));
    checkOutput({tag, ".count"}, 32'(wr_count),    32'(occ));
    checkOutput({tag, ".full"},  32'(full),        32'(mFull));
    checkOutput({tag, ".af"},    32'(almost_full), 32'(occ >= AF));
    checkOutput({tag, ".ovf"},   32'(overflow),    32'(expOvf));
  endtask

  initial begin
    vec_t v;
    int   nr;
    logic [3:0] prevGray;

    rst = 1'b1;
    wr_en = 1'b0;
    rd_ptr_gray_sync = '0;
    #2;

    // Directed table: reset, idle, fill, overflow, read release, one more write.
    vecs.push_back('{1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < 5; i++)
      vecs.push_back('{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'h0, 1'b1, 4'h1, 3'd1, 4'd1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'h0, 1'b1, 4'h3, 3'd2, 4'd2, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'h0, 1'b1, 4'h2, 3'd3, 4'd3, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'h0, 1'b1, 4'h6, 3'd4, 4'd4, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'h0, 1'b1, 4'h7, 3'd5, 4'd5, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'h0, 1'b1, 4'h5, 3'd6, 4'd6, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'h0, 1'b1, 4'h4, 3'd7, 4'd7, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'h0, 1'b1, 4'hC, 3'd0, 4'd8, 1'b1, 1'b1, 1'b0});
    for (int i = 0; i < 3; i++)
      vecs.push_back('{1'b0, 1'b1, 4'h0, 1'b0, 4'hC, 3'd0, 4'd8, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 4'h3, 1'b0, 4'hC, 3'd0, 4'd6, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'h3, 1'b1, 4'hD, 3'd1, 4'd7, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'h3, 1'b0, 4'hD, 3'd1, 4'd7, 1'b0, 1'b1, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      applyStimulus(v.rst, v.wrEn, v.rdG);
      checkOutput($sformatf("vec%0d.memEn", i), 32'(wr_mem_en), 32'(v.memEn));
      stepEdge();
      checkOutput($sformatf("vec%0d.gray", i),  32'(wr_ptr_gray), 32'(v.gray));
      checkOutput($sformatf("vec%0d.addr", i),  32'(wr_addr),     32'(v.addr));
      checkOutput($sformatf("vec%0d.count", i), 32'(wr_count),    32'(v.count));
      checkOutput($sformatf("vec%0d.full", i),  32'(full),        32'(v.full));
      checkOutput($sformatf("vec%0d.af", i),    32'(almost_full), 32'(v.af));
      checkOutput($sformatf("vec%0d.ovf", i),   32'(overflow),    32'(v.ovf));
    end

    // Wrap-around: 20 writes with the reader trailing by two.
    cycleModel(1'b1, 1'b0, 0, "wrapRst");
    for (int i = 0; i < 20; i++) begin
      nr = (mWrites >= 2) ? mWrites - 2 : 0;
      prevGray = wr_ptr_gray;
      cycleModel(1'b0, 1'b1, nr, "wrap");
      checkOutput("wrap.oneBit", 32'($countones(prevGray ^ wr_ptr_gray)), 32'd1);
      if (mWrites == 16)
        checkOutput("wrap.8to0", {24'd0, prevGray, wr_ptr_gray}, 32'h80);
    end

    // Reset in the middle of a write burst, then restart from address 0.
    cycleModel(1'b1, 1'b0, 0, "burstRst");
    for (int i = 0; i < 3; i++)
      cycleModel(1'b0, 1'b1, 0, "burst");
    cycleModel(1'b1, 1'b1, 0, "midRst");
    applyStimulus(1'b0, 1'b1, 4'h0);
    checkOutput("restart.addr", 32'(wr_addr), 32'd0);
    checkOutput("restart.memEn", 32'(wr_mem_en), 32'd1);
    stepEdge();
    mWrites = 1;
    checkOutput("restart.addrNext", 32'(wr_addr), 32'd1);
    checkOutput("restart.gray", 32'(wr_ptr_gray), 32'h1);

    // Random traffic: write-heavy first half, read-heavy second half.
    for (int i = 0; i < 600; i++) begin
      bit r;
      bit w;
      r = ($urandom_range(0, 79) == 0);
      w = (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
      nr = mReads;
      if (r)
        nr = 0;
      else if (mReads < mWrites && $urandom_range(0, 99) < ((i < 300) ? 30 : 70))
        nr = mReads + 1;
      cycleModel(r, w, nr, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
